// File: rtl/line_window_reader_pkg.sv
// Shared constants, derived widths and FSM state encodings for the line-buffer read path.
package line_window_reader_pkg;

    localparam int PIX_W     = 8;
    localparam int LINE_W    = 9;
    localparam int NUM_LINES = 4;

    localparam int COL_W  = $clog2(LINE_W);
    localparam int FILL_W = $clog2(NUM_LINES * LINE_W + 1);
    localparam int LINE_IDX_W = 2;

    typedef logic [0:0] state_t;
    localparam state_t IDLE = 1'b0;
    localparam state_t READ = 1'b1;

endpackage

// File: rtl/window_line_store.sv
// One image line of pixels: single write port, three adjacent combinational read taps.
module window_line_store
    import line_window_reader_pkg::*;
(
    input  logic             clk,
    input  logic             we,
    input  logic [COL_W-1:0] wr_col,
    input  logic [PIX_W-1:0] wr_data,
    input  logic [COL_W-1:0] rd_col,
    output logic [PIX_W-1:0] tap0,
    output logic [PIX_W-1:0] tap1,
    output logic [PIX_W-1:0] tap2
);

    logic [PIX_W-1:0] mem [LINE_W];

    // NOTE: pixel storage has no reset; contents are meaningless until written and
    // the fill count guarantees nothing unwritten is ever read.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_col] <= wr_data;
        end
    end

    // rd_col never exceeds LINE_W-3, so rd_col+2 stays inside the line.
    assign tap0 = mem[rd_col];
    assign tap1 = mem[rd_col + COL_W'(1)];
    assign tap2 = mem[rd_col + COL_W'(2)];

endmodule

// File: rtl/line_window_reader.sv
// Line-buffer read controller: stores a raster stream in four line stores and emits 3x3 windows.
module line_window_reader
    import line_window_reader_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic [PIX_W-1:0]   in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [9*PIX_W-1:0] out_window,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               line_done
);

    localparam logic [FILL_W-1:0] FILL_MAX  = FILL_W'(NUM_LINES * LINE_W);
    localparam logic [FILL_W-1:0] FILL_READ = FILL_W'(3 * LINE_W);
    localparam logic [FILL_W-1:0] FILL_LINE = FILL_W'(LINE_W);
    localparam logic [COL_W-1:0]  RD_LAST   = COL_W'(LINE_W - 3);
    localparam logic [COL_W-1:0]  WR_LAST   = COL_W'(LINE_W - 1);

    state_t                  state;
    logic [LINE_IDX_W-1:0]   wr_line;
    logic [LINE_IDX_W-1:0]   rd_base;
    logic [COL_W-1:0]        wr_col;
    logic [COL_W-1:0]        rd_col;
    logic [FILL_W-1:0]       fill;
    logic [FILL_W-1:0]       fill_next;

    logic wr_en;
    logic accept;
    logic pass_end;

    logic [PIX_W-1:0] taps [NUM_LINES][3];
    logic [LINE_IDX_W-1:0] top_line;
    logic [LINE_IDX_W-1:0] mid_line;
    logic [LINE_IDX_W-1:0] bot_line;

    assign in_ready  = (fill < FILL_MAX);
    assign out_valid = (state == READ);
    assign wr_en     = in_valid && in_ready;
    assign accept    = out_valid && out_ready;
    assign pass_end  = accept && (rd_col == RD_LAST);

    for (genvar i = 0; i < NUM_LINES; i++) begin : g_store
        window_line_store u_store (
            .clk     (clk),
            .we      (wr_en && (wr_line == LINE_IDX_W'(i))),
            .wr_col  (wr_col),
            .wr_data (in_data),
            .rd_col  (rd_col),
            .tap0    (taps[i][0]),
            .tap1    (taps[i][1]),
            .tap2    (taps[i][2])
        );
    end

    // Two-bit line indices wrap naturally, giving the mod-4 row selection.
    assign top_line = rd_base;
    assign mid_line = rd_base + LINE_IDX_W'(1);
    assign bot_line = rd_base + LINE_IDX_W'(2);

    assign out_window = {taps[top_line][0], taps[top_line][1], taps[top_line][2],
                         taps[mid_line][0], taps[mid_line][1], taps[mid_line][2],
                         taps[bot_line][0], taps[bot_line][1], taps[bot_line][2]};

    // NOTE: fill_next is assigned a default before any conditional update so no latch is inferred.
    always_comb begin
        fill_next = fill;
        if (wr_en) begin
            fill_next = fill_next + FILL_W'(1);
        end
        if (pass_end) begin
            fill_next = fill_next - FILL_LINE;
        end
    end

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            wr_line   <= '0;
            wr_col    <= '0;
            rd_base   <= '0;
            rd_col    <= '0;
            fill      <= '0;
            line_done <= 1'b0;
        end else begin
            fill      <= fill_next;
            line_done <= pass_end;

            if (wr_en) begin
                if (wr_col == WR_LAST) begin
                    wr_col  <= '0;
                    wr_line <= wr_line + LINE_IDX_W'(1);
                end else begin
                    wr_col <= wr_col + COL_W'(1);
                end
            end

            case (state)
                IDLE: begin
                    if (fill >= FILL_READ) begin
                        state <= READ;
                    end
                end
                READ: begin
                    if (pass_end) begin
                        rd_col  <= '0;
                        rd_base <= rd_base + LINE_IDX_W'(1);
                        state   <= IDLE;
                    end else if (accept) begin
                        rd_col <= rd_col + COL_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_line_window_reader.sv
// Directed self-checking bench for line_window_reader with hand-computed windows.
module tb_line_window_reader;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [71:0] out_window;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        line_done;

    int vectors = 0;
    int miscompares = 0;

    line_window_reader dut (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_window (out_window),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .line_done  (line_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Sample/drive point is 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Window whose top line starts at pixel value base; following lines are base+9, base+18.
    function automatic logic [71:0] exp_win(input int base, input int c);
        logic [71:0] w;
        w = '0;
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 3; k++) begin
                w = {w[63:0], 8'(base + 9 * r + c + k)};
            end
        end
        return w;
    endfunction

    task automatic do_reset(input string tag);
        reset    = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        tick();
        check({tag, "_rst_valid"}, 72'(out_valid), 72'(0));
        check({tag, "_rst_done"}, 72'(line_done), 72'(0));
        check({tag, "_rst_ready"}, 72'(in_ready), 72'(1));
        reset = 1'b1;
    endtask

    task automatic write_range(input int lo, input int hi);
        for (int v = lo; v <= hi; v++) begin
            in_valid = 1'b1;
            in_data  = 8'(v);
            tick();
        end
        in_valid = 1'b0;
    endtask

    // Runs one pass from the current sample point; stalls stall_len cycles at window stall_at.
    task automatic run_pass(input int base, input int stall_at, input int stall_len, input string tag);
        int c = 0;
        int stalls = 0;
        int budget = 0;
        while (c < 7 && budget < 64) begin
            check({tag, "_valid"}, 72'(out_valid), 72'(1));
            check({tag, "_win"}, out_window, exp_win(base, c));
            if (c == stall_at && stalls < stall_len) begin
                out_ready = 1'b0;
                stalls++;
            end else begin
                out_ready = 1'b1;
                c++;
            end
            tick();
            budget++;
        end
        check({tag, "_budget"}, 72'(budget < 64), 72'(1));
        check({tag, "_done_pulse"}, 72'(line_done), 72'(1));
        check({tag, "_idle_after"}, 72'(out_valid), 72'(0));
        tick();
        check({tag, "_done_clear"}, 72'(line_done), 72'(0));
    endtask

    task automatic basic_body(input string tag);
        out_ready = 1'b1;
        write_range(0, 26);
        check({tag, "_lag"}, 72'(out_valid), 72'(0));
        tick();
        run_pass(0, -1, 0, tag);
        check({tag, "_fill"}, 72'(dut.fill), 72'(18));
        check({tag, "_stay_idle"}, 72'(out_valid), 72'(0));
    endtask

    initial begin
        // Scenario 1: first fill and a clean pass.
        do_reset("s1");
        basic_body("s1");

        // Scenario 2: backpressure at the third window.
        do_reset("s2");
        out_ready = 1'b1;
        write_range(0, 26);
        tick();
        run_pass(0, 2, 5, "s2");

        // Scenario 3: fill to capacity with the reader stalled.
        do_reset("s3");
        write_range(0, 34);
        check("s3_ready_35", 72'(in_ready), 72'(1));
        write_range(35, 35);
        check("s3_ready_full", 72'(in_ready), 72'(0));
        check("s3_fill_full", 72'(dut.fill), 72'(36));
        in_valid = 1'b1;
        in_data  = 8'hEE;
        tick();
        in_valid = 1'b0;
        check("s3_fill_blocked", 72'(dut.fill), 72'(36));
        check("s3_hold_win", out_window, exp_win(0, 0));
        run_pass(0, -1, 0, "s3p0");
        check("s3_ready_after", 72'(in_ready), 72'(1));
        check("s3_fill_after", 72'(dut.fill), 72'(27));
        run_pass(9, -1, 0, "s3p1");
        write_range(36, 44);
        tick();
        run_pass(18, -1, 0, "s3p2");

        // Scenario 4: write lands on the same cycle as the last accept.
        do_reset("s4");
        write_range(0, 29);
        for (int c = 0; c < 6; c++) begin
            check("s4_win", out_window, exp_win(0, c));
            out_ready = 1'b1;
            tick();
        end
        check("s4_last_win", out_window, exp_win(0, 6));
        in_valid = 1'b1;
        in_data  = 8'd30;
        tick();
        in_valid = 1'b0;
        check("s4_fill", 72'(dut.fill), 72'(22));
        check("s4_done", 72'(line_done), 72'(1));

        // Scenario 5: six lines, four passes, wrap of the store index.
        do_reset("s5");
        out_ready = 1'b1;
        write_range(0, 26);
        tick();
        run_pass(0, -1, 0, "s5p0");
        for (int p = 1; p < 4; p++) begin
            write_range(18 + 9 * p, 26 + 9 * p);
            tick();
            run_pass(9 * p, -1, 0, $sformatf("s5p%0d", p));
        end

        // Scenario 6: reset in the middle of a pass.
        do_reset("s6");
        out_ready = 1'b1;
        write_range(0, 26);
        tick();
        for (int c = 0; c < 3; c++) tick();
        check("s6_win3", out_window, exp_win(0, 3));
        reset = 1'b0;
        #1;
        check("s6_abort_valid", 72'(out_valid), 72'(0));
        check("s6_abort_ready", 72'(in_ready), 72'(1));
        check("s6_abort_done", 72'(line_done), 72'(0));
        check("s6_abort_fill", 72'(dut.fill), 72'(0));
        tick();
        check("s6_no_done", 72'(line_done), 72'(0));
        reset = 1'b1;
        basic_body("s6r");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
